lfsr_prng_stream: RTL and testbench



---
 rtl/lfsr_prng_pkg.sv | 31 +++
 rtl/lfsr_prng_stream_core.sv | 55 +++++
 rtl/lfsr_prng_stream.sv | 146 ++++++++++++++
 tb/tb_lfsr_prng_stream.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_prng_pkg.sv
// Shared definitions for the LFSR pseudo-random stream generator:
// operating modes, default Galois feedback masks and the single-step function.
package lfsr_prng_pkg;

    // Operating modes selected by the 2-bit mode input
    typedef enum logic [1:0] {
        MODE_HOLD     = 2'd0,
        MODE_RUN      = 2'd1,
        MODE_SEED_SER = 2'd2,
        MODE_SEED_PAR = 2'd3
    } mode_e;

    // Right-shift Galois feedback masks (top bit always set)
    localparam logic [31:0] POLY_32 = 32'h8020_0003; // x^32+x^22+x^2+x+1
    localparam logic [15:0] POLY_16 = 16'hB400;      // x^16+x^14+x^13+x^11+1
    localparam logic [7:0]  POLY_8  = 8'hB8;         // x^8+x^6+x^5+x^4+1

    // One Galois step on a zero-extended state. A zero state is treated like
    // a state with its LSB set, so the feedback mask is injected and the
    // register can never stay stuck at zero.
    function automatic logic [63:0] next_state(input logic [63:0] state,
                                               input logic [63:0] poly);
        logic [63:0] shifted;
        shifted = state >> 1;
        if (state[0] || (state == 64'd0)) begin
            return shifted ^ poly;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/lfsr_prng_stream_core.sv
// LFSR state register: Galois step, serial and parallel seed load and the
// zero-state guard with its registered lockup pulse.
module lfsr_core
    import lfsr_prng_pkg::*;
#(
    parameter int              WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY = POLY_32,
    parameter logic [WIDTH-1:0] SEED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             step_i,
    input  logic             ser_load_i,
    input  logic             par_load_i,
    input  logic             seed_bit_i,
    input  logic [WIDTH-1:0] seed_in_i,
    output logic [WIDTH-1:0] state_o,
    output logic             lockup_o
);

    logic [WIDTH-1:0] state_q, state_d;
    logic             lockup_q, lockup_d;

    // Select the next state: seed loads take priority over stepping
    always_comb begin
        state_d  = state_q;
        lockup_d = 1'b0;
        if (en_i) begin
            if (par_load_i) begin
                state_d = seed_in_i;
            end else if (ser_load_i) begin
                state_d = {seed_bit_i, state_q[WIDTH-1:1]};
            end else if (step_i) begin
                state_d  = WIDTH'(next_state(64'(state_q), 64'(POLY)));
                lockup_d = (state_q == '0);
            end
        end
    end

    // State and lockup registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= SEED;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lockup_q <= lockup_d;
        end
    end

    assign state_o  = state_q;
    assign lockup_o = lockup_q;

endmodule

// File: rtl/lfsr_prng_stream.sv
// Top level of the LFSR pseudo-random word stream. Each output word is built
// from OUT_W fresh LFSR steps; a full output slot stalls the LFSR.
// Optional feature macro: LFSR_STEP_CNT_EN adds a 32-bit executed-step counter.
module lfsr_prng_stream
    import lfsr_prng_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = POLY_32,
    parameter logic [WIDTH-1:0] SEED  = 1,
    parameter int               OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             seed_bit,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state_o,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lockup
`ifdef LFSR_STEP_CNT_EN
    ,
    output logic [31:0]      step_cnt
`endif
);

    localparam int               CNT_W    = $clog2(OUT_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUT_W);

    mode_e            mode_sel;
    logic             step;
    logic             ser_load;
    logic             par_load;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
`ifdef LFSR_STEP_CNT_EN
    logic [31:0]      step_cnt_q, step_cnt_d;
`endif

    assign mode_sel = mode_e'(mode);

    lfsr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en),
        .step_i     (step),
        .ser_load_i (ser_load),
        .par_load_i (par_load),
        .seed_bit_i (seed_bit),
        .seed_in_i  (seed_in),
        .state_o    (state_o),
        .lockup_o   (lockup)
    );

    // Mode decode, word capture, stall and valid/ready retirement
    always_comb begin
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = valid_q;
        step     = 1'b0;
        ser_load = 1'b0;
        par_load = 1'b0;
`ifdef LFSR_STEP_CNT_EN
        step_cnt_d = step_cnt_q;
`endif
        if (en) begin
            case (mode_sel)
                MODE_HOLD: begin
                    if (valid_q && out_ready) begin
                        valid_d = 1'b0;
                    end
                end
                MODE_RUN: begin
                    if (cnt_q != CNT_FULL) begin
                        step  = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                        if (valid_q && out_ready) begin
                            valid_d = 1'b0;
                        end
                    end else if (!valid_q || out_ready) begin
                        data_d  = state_o[OUT_W-1:0];
                        valid_d = 1'b1;
                        step    = 1'b1;
                        cnt_d   = CNT_W'(1);
                    end
                end
                MODE_SEED_SER: begin
                    ser_load = 1'b1;
                    cnt_d    = '0;
                    valid_d  = 1'b0;
                end
                MODE_SEED_PAR: begin
                    par_load = 1'b1;
                    cnt_d    = '0;
                    valid_d  = 1'b0;
                end
                default: begin
                end
            endcase
`ifdef LFSR_STEP_CNT_EN
            if (ser_load || par_load) begin
                step_cnt_d = '0;
            end else if (step) begin
                step_cnt_d = step_cnt_q + 32'd1;
            end
`endif
        end
    end

    // Counter, output word and valid flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef LFSR_STEP_CNT_EN
    // Executed-step counter, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_cnt_q <= '0;
        end else begin
            step_cnt_q <= step_cnt_d;
        end
    end

    assign step_cnt = step_cnt_q;
`endif

    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_lfsr_prng_stream.sv
// Directed testbench for lfsr_prng_stream with default parameters.
// Build with +define+LFSR_STEP_CNT_EN to also check the step counter.
module tb_lfsr_prng_stream;

    localparam logic [31:0] P = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic        seed_bit;
    logic [31:0] seed_in;
    logic [31:0] state_o;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        lockup;
`ifdef LFSR_STEP_CNT_EN
    logic [31:0] step_cnt;
`endif

    int nChecks = 0;
    int nFail   = 0;

    lfsr_prng_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .seed_bit  (seed_bit),
        .seed_in   (seed_in),
        .state_o   (state_o),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lockup    (lockup)
`ifdef LFSR_STEP_CNT_EN
        ,
        .step_cnt  (step_cnt)
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Reference Galois step
    function automatic logic [31:0] ref_step(input logic [31:0] s);
        if (s[0] == 1'b1 || s == 32'd0) return {1'b0, s[31:1]} ^ P;
        return {1'b0, s[31:1]};
    endfunction

    // Reference state after n steps from a start value
    function automatic logic [31:0] ref_n(input logic [31:0] start, input int n);
        logic [31:0] s;
        s = start;
        for (int i = 0; i < n; i++) s = ref_step(s);
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyReset();
        rst_n = 1'b0; en = 1'b1; mode = 2'd0; out_ready = 1'b0;
        seed_bit = 1'b0; seed_in = 32'd0;
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        applyReset();
        mode = 2'd1; out_ready = 1'b1;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        nChecks++; if (state_o !== 32'd1) begin nFail++; $display("[TB] FAIL reset_state: got %h want %h", state_o, 32'd1); end
        nChecks++; if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
        nChecks++; if (out_data !== 8'd0) begin nFail++; $display("[TB] FAIL reset_data: got %h want 00", out_data); end
        nChecks++; if (lockup !== 1'b0) begin nFail++; $display("[TB] FAIL reset_lockup: got %b want 0", lockup); end
        rst_n = 1'b1; mode = 2'd0;
    endtask

    task automatic test_run_sequence();
        logic [31:0] expSeq [3];
        expSeq[0] = 32'h8020_0003; expSeq[1] = 32'hC030_0002; expSeq[2] = 32'h6018_0001;
        applyReset();
        mode = 2'd1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            nChecks++; if (state_o !== expSeq[i]) begin nFail++; $display("[TB] FAIL run_seq%0d: got %h want %h", i, state_o, expSeq[i]); end
        end
    endtask

    task automatic test_first_word();
        int  cycles;
        logic seen;
        logic [31:0] expS;
        applyReset();
        mode = 2'd1; out_ready = 1'b1;
        cycles = 0; seen = 1'b0;
        while (!seen && cycles < 20) begin
            tick(1);
            cycles++;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        nChecks++; if (cycles != 9) begin nFail++; $display("[TB] FAIL first_word_latency: got %0d want 9", cycles); end
        expS = ref_n(32'd1, 8);
        nChecks++; if (out_data !== expS[7:0]) begin nFail++; $display("[TB] FAIL first_word_data: got %h want %h", out_data, expS[7:0]); end
`ifdef LFSR_STEP_CNT_EN
        nChecks++; if (step_cnt !== 32'd9) begin nFail++; $display("[TB] FAIL step_cnt_first: got %0d want 9", step_cnt); end
`endif
        for (int k = 2; k <= 3; k++) begin
            tick(1);
            nChecks++; if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL retire_w%0d: got %b want 0", k, out_valid); end
            tick(7);
            expS = ref_n(32'd1, 8 * k);
            nChecks++; if (out_valid !== 1'b1) begin nFail++; $display("[TB] FAIL valid_w%0d: got %b want 1", k, out_valid); end
            nChecks++; if (out_data !== expS[7:0]) begin nFail++; $display("[TB] FAIL data_w%0d: got %h want %h", k, out_data, expS[7:0]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] s8, s16, s17;
        s8 = ref_n(32'd1, 8); s16 = ref_n(32'd1, 16); s17 = ref_n(32'd1, 17);
        applyReset();
        mode = 2'd1; out_ready = 1'b0;
        tick(20);
        nChecks++; if (state_o !== s16) begin nFail++; $display("[TB] FAIL stall_state: got %h want %h", state_o, s16); end
        nChecks++; if (out_valid !== 1'b1) begin nFail++; $display("[TB] FAIL stall_valid: got %b want 1", out_valid); end
        nChecks++; if (out_data !== s8[7:0]) begin nFail++; $display("[TB] FAIL stall_data: got %h want %h", out_data, s8[7:0]); end
`ifdef LFSR_STEP_CNT_EN
        nChecks++; if (step_cnt !== 32'd16) begin nFail++; $display("[TB] FAIL step_cnt_stall: got %0d want 16", step_cnt); end
`endif
        tick(2);
        nChecks++; if (state_o !== s16) begin nFail++; $display("[TB] FAIL stall_frozen: got %h want %h", state_o, s16); end
        out_ready = 1'b1;
        tick(1);
        nChecks++; if (out_valid !== 1'b1) begin nFail++; $display("[TB] FAIL resume_valid: got %b want 1", out_valid); end
        nChecks++; if (out_data !== s16[7:0]) begin nFail++; $display("[TB] FAIL resume_data: got %h want %h", out_data, s16[7:0]); end
        nChecks++; if (state_o !== s17) begin nFail++; $display("[TB] FAIL resume_state: got %h want %h", state_o, s17); end
    endtask

    task automatic test_enable_hold();
        logic [31:0] s3, s4, s8;
        s3 = ref_n(32'd1, 3); s4 = ref_n(32'd1, 4); s8 = ref_n(32'd1, 8);
        applyReset();
        mode = 2'd1; out_ready = 1'b1;
        tick(3);
        en = 1'b0;
        tick(4);
        nChecks++; if (state_o !== s3) begin nFail++; $display("[TB] FAIL en_hold: got %h want %h", state_o, s3); end
        en = 1'b1;
        tick(1);
        nChecks++; if (state_o !== s4) begin nFail++; $display("[TB] FAIL en_resume: got %h want %h", state_o, s4); end
        mode = 2'd0;
        tick(3);
        nChecks++; if (state_o !== s4) begin nFail++; $display("[TB] FAIL hold_mode: got %h want %h", state_o, s4); end
        mode = 2'd1;
        tick(4);
        nChecks++; if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL hold_cnt_pre: got %b want 0", out_valid); end
        tick(1);
        nChecks++; if (out_valid !== 1'b1) begin nFail++; $display("[TB] FAIL hold_cnt_word: got %b want 1", out_valid); end
        nChecks++; if (out_data !== s8[7:0]) begin nFail++; $display("[TB] FAIL hold_cnt_data: got %h want %h", out_data, s8[7:0]); end
    endtask

    task automatic test_lockup();
        applyReset();
        mode = 2'd3; seed_in = 32'd0;
        tick(1);
        nChecks++; if (state_o !== 32'd0) begin nFail++; $display("[TB] FAIL par_zero: got %h want 0", state_o); end
        mode = 2'd1; out_ready = 1'b1;
        tick(1);
        nChecks++; if (lockup !== 1'b1) begin nFail++; $display("[TB] FAIL lockup_pulse: got %b want 1", lockup); end
        nChecks++; if (state_o !== P) begin nFail++; $display("[TB] FAIL lockup_state: got %h want %h", state_o, P); end
        tick(1);
        nChecks++; if (lockup !== 1'b0) begin nFail++; $display("[TB] FAIL lockup_clear: got %b want 0", lockup); end
        nChecks++; if (state_o !== 32'hC030_0002) begin nFail++; $display("[TB] FAIL lockup_next: got %h want c0300002", state_o); end
    endtask

    task automatic test_seed_ser();
        logic [31:0] pat;
        logic [31:0] s8;
        pat = 32'hDEAD_BEEF;
        s8  = ref_n(pat, 8);
        applyReset();
        mode = 2'd1; out_ready = 1'b0;
        tick(9);
        nChecks++; if (out_valid !== 1'b1) begin nFail++; $display("[TB] FAIL ser_pre_valid: got %b want 1", out_valid); end
        mode = 2'd2;
        for (int i = 0; i < 32; i++) begin
            seed_bit = pat[i];
            tick(1);
        end
        nChecks++; if (state_o !== pat) begin nFail++; $display("[TB] FAIL ser_state: got %h want %h", state_o, pat); end
        nChecks++; if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL ser_valid: got %b want 0", out_valid); end
`ifdef LFSR_STEP_CNT_EN
        nChecks++; if (step_cnt !== 32'd0) begin nFail++; $display("[TB] FAIL step_cnt_seed: got %0d want 0", step_cnt); end
`endif
        mode = 2'd1; out_ready = 1'b1;
        tick(8);
        nChecks++; if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL ser_cnt_pre: got %b want 0", out_valid); end
        tick(1);
        nChecks++; if (out_valid !== 1'b1) begin nFail++; $display("[TB] FAIL ser_cnt_word: got %b want 1", out_valid); end
        nChecks++; if (out_data !== s8[7:0]) begin nFail++; $display("[TB] FAIL ser_word_data: got %h want %h", out_data, s8[7:0]); end
    endtask

    task automatic test_reset_midword();
        applyReset();
        mode = 2'd1; out_ready = 1'b0;
        tick(12);
        nChecks++; if (out_valid !== 1'b1) begin nFail++; $display("[TB] FAIL mid_pre_valid: got %b want 1", out_valid); end
        rst_n = 1'b0;
        tick(1);
        nChecks++; if (state_o !== 32'd1) begin nFail++; $display("[TB] FAIL mid_state: got %h want 1", state_o); end
        nChecks++; if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL mid_valid: got %b want 0", out_valid); end
        nChecks++; if (out_data !== 8'd0) begin nFail++; $display("[TB] FAIL mid_data: got %h want 00", out_data); end
`ifdef LFSR_STEP_CNT_EN
        nChecks++; if (step_cnt !== 32'd0) begin nFail++; $display("[TB] FAIL mid_step_cnt: got %0d want 0", step_cnt); end
`endif
        rst_n = 1'b1;
    endtask

    // Overall time bound so a stuck run still ends with a report
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    // Scenario sequence
    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 2'd0; out_ready = 1'b0;
        seed_bit = 1'b0; seed_in = 32'd0;
        test_reset();
        test_run_sequence();
        test_first_word();
        test_backpressure();
        test_enable_hold();
        test_lockup();
        test_seed_ser();
        test_reset_midword();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
